// File: rtl/gshare_pkg.sv
// Shared types and the 2-bit saturating counter update for the gshare predictor.
package gshare_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } pht_ctr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } gshare_state_t;

    function automatic pht_ctr_t sat_update(input pht_ctr_t ctr, input logic taken);
        pht_ctr_t nxt;
        unique case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_pht_bank.sv
// Pattern history table: one combinational read port, one write port shared by the
// init sweep (writes WNT) and training (read-modify-write of the addressed counter).
module gshare_pht_bank
    import gshare_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    output pht_ctr_t              rd_ctr_o,
    input  logic                  init_we_i,
    input  logic [INDEX_BITS-1:0] init_index_i,
    input  logic                  train_we_i,
    input  logic [INDEX_BITS-1:0] train_index_i,
    input  logic                  train_taken_i
);

    localparam int unsigned Depth = 2 ** INDEX_BITS;

    pht_ctr_t              mem_q [Depth];
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_index;
    pht_ctr_t              wr_ctr;

    assign rd_ctr_o = mem_q[rd_index_i];

    // The init sweep owns the write port; training is only asserted in RUN.
    always_comb begin
        wr_en    = 1'b0;
        wr_index = '0;
        wr_ctr   = WNT;
        if (init_we_i) begin
            wr_en    = 1'b1;
            wr_index = init_index_i;
            wr_ctr   = WNT;
        end else if (train_we_i) begin
            wr_en    = 1'b1;
            wr_index = train_index_i;
            wr_ctr   = sat_update(mem_q[train_index_i], train_taken_i);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_index] <= wr_ctr;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: XOR-folded {pc, ghr} index, registered prediction, history repair.
// Optional lookup/mispredict statistics outputs are enabled by defining GSHARE_STATS_EN.
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int unsigned GHR_LEN      = 8,
    parameter int unsigned PC_HASH_BITS = 8,
    parameter int unsigned INDEX_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [31:0]           i_req_pc,
    output logic                  o_ready,
    output logic                  o_pred_valid,
    output logic                  o_pred_taken,
    output logic [INDEX_BITS-1:0] o_pred_index,
    output logic [GHR_LEN-1:0]    o_pred_ghr,
    input  logic                  i_upd_valid,
    input  logic [INDEX_BITS-1:0] i_upd_index,
    input  logic [GHR_LEN-1:0]    i_upd_ghr,
    input  logic                  i_upd_taken,
    input  logic                  i_upd_mispredict
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]           o_stat_lookups,
    output logic [31:0]           o_stat_mispredicts
`endif
);

    localparam int unsigned FoldW = PC_HASH_BITS + GHR_LEN;

    gshare_state_t         state_q, state_d;
    logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
    logic [GHR_LEN-1:0]    ghr_q, ghr_d;
    logic                  pred_valid_q;
    logic                  pred_taken_q;
    logic [INDEX_BITS-1:0] pred_index_q;
    logic [GHR_LEN-1:0]    pred_ghr_q;

    logic [FoldW-1:0]      fold_src;
    logic [INDEX_BITS-1:0] fold_index;
    pht_ctr_t              rd_ctr;
    logic                  pred_taken;
    logic                  accept;
    logic                  train;
    logic                  unused_bits;

    assign unused_bits = ^{i_req_pc[31:PC_HASH_BITS+2], i_req_pc[1:0], i_upd_ghr[GHR_LEN-1]};

    assign fold_src = {i_req_pc[PC_HASH_BITS+1:2], ghr_q};

    always_comb begin
        fold_index = '0;
        for (int i = 0; i < int'(FoldW); i++) begin
            fold_index[i % INDEX_BITS] = fold_index[i % INDEX_BITS] ^ fold_src[i];
        end
    end

    assign o_ready    = (state_q == RUN) & ~(i_upd_valid & i_upd_mispredict);
    assign accept     = i_req_valid & o_ready;
    assign train      = (state_q == RUN) & i_upd_valid;
    assign pred_taken = rd_ctr inside {WT, ST};

    gshare_pht_bank #(
        .INDEX_BITS (INDEX_BITS)
    ) u_pht (
        .clk           (clk),
        .rd_index_i    (fold_index),
        .rd_ctr_o      (rd_ctr),
        .init_we_i     (state_q == INIT),
        .init_index_i  (init_ptr_q),
        .train_we_i    (train),
        .train_index_i (i_upd_index),
        .train_taken_i (i_upd_taken)
    );

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        unique case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // A mispredict blocks acceptance, so repair and speculative shift never collide.
    always_comb begin
        ghr_d = ghr_q;
        if (train && i_upd_mispredict) begin
            ghr_d = {i_upd_ghr[GHR_LEN-2:0], i_upd_taken};
        end else if (accept) begin
            ghr_d = {ghr_q[GHR_LEN-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            init_ptr_q   <= '0;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
            pred_ghr_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= accept;
            if (accept) begin
                pred_taken_q <= pred_taken;
                pred_index_q <= fold_index;
                pred_ghr_q   <= ghr_q;
            end
        end
    end

    assign o_pred_valid = pred_valid_q;
    assign o_pred_taken = pred_taken_q;
    assign o_pred_index = pred_index_q;
    assign o_pred_ghr   = pred_ghr_q;

`ifdef GSHARE_STATS_EN
    logic [31:0] stat_lookups_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (accept) begin
                stat_lookups_q <= stat_lookups_q + 32'd1;
            end
            if (train && i_upd_mispredict) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign o_stat_lookups     = stat_lookups_q;
    assign o_stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
